axi_rd_arbiter: RTL and testbench

- Shares one AXI4 read master (AR/R channels) between the instruction cache (port 0) and the data cache (port 1).
- Each cache uses the codebase's simple refill request interface:
  - Request side: addr_valid / addr / data_len.
  - Response side: resp_ready / data_valid / data.
- One transaction is outstanding at a time. Arbitration is round-robin. Simultaneous icache and dcache misses are serialised.
- Sits between the caches and the top-level AXI bridge.

---
 rtl/axi_rd_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master between the icache (port 0)
// and the dcache (port 1); one burst in flight at a time, beats forwarded in order.
module axi_rd_arbiter #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 addr_valid_i,
  input  logic [1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0][7:0]            data_len_i,
  output logic [1:0]                 resp_ready_o,
  output logic [1:0]                 data_valid_o,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic                       arvalid_o,
  input  logic                       arready_i,
  output logic [ADDR_WIDTH-1:0]      araddr_o,
  output logic [7:0]                 arlen_o,
  output logic [2:0]                 arsize_o,
  output logic [1:0]                 arburst_o,
  output logic [ID_WIDTH-1:0]        arid_o,
  input  logic                       rvalid_i,
  output logic                       rready_o,
  input  logic [DATA_WIDTH-1:0]      rdata_i,
  input  logic [1:0]                 rresp_i,
  input  logic                       rlast_i,
  input  logic [ID_WIDTH-1:0]        rid_i,
  output logic                       err_o
);

  localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  state_t                       state_r, state_nxt_s;
  logic [1:0]                   pending_r;
  logic [1:0][ADDR_WIDTH-1:0]   slot_addr_r;
  logic [1:0][7:0]              slot_len_r;
  logic                         last_grant_r;
  logic                         active_r;
  logic [7:0]                   beat_cnt_r;
  logic [1:0]                   resp_ready_r;
  logic [1:0]                   data_valid_r;
  logic [DATA_WIDTH-1:0]        data_r;
  logic                         arvalid_r;
  logic [ADDR_WIDTH-1:0]        araddr_r;
  logic [7:0]                   arlen_r;
  logic [2:0]                   arsize_r;
  logic [1:0]                   arburst_r;
  logic [ID_WIDTH-1:0]          arid_r;
  logic                         rready_r;
  logic                         err_r;

  logic                         grant_vld_s;
  logic                         grant_port_s;
  logic                         burst_end_s;
  logic [1:0]                   grant_vec_s;
  logic [1:0]                   active_vec_s;
  logic [1:0]                   req_drop_s;
  logic [1:0]                   req_acc_s;
  logic                         beat_s;
  logic                         r_err_s;

  assign beat_s       = rvalid_i & rready_r;
  assign active_vec_s = (state_r == ST_IDLE) ? 2'b00 : (active_r ? 2'b10 : 2'b01);
  assign grant_vec_s  = grant_vld_s ? (grant_port_s ? 2'b10 : 2'b01) : 2'b00;
  // A port may hold one request: re-requests while pending or in service are dropped
  assign req_drop_s   = addr_valid_i & (pending_r | active_vec_s);
  assign req_acc_s    = addr_valid_i & ~req_drop_s;
  assign r_err_s      = beat_s & ((rid_i != arid_r) | (rresp_i != 2'b00) |
                                  (rlast_i != (beat_cnt_r == arlen_r)));

  // Next-state and grant selection
  always_comb begin
    state_nxt_s  = state_r;
    grant_vld_s  = 1'b0;
    grant_port_s = 1'b0;
    burst_end_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pending_r != 2'b00) begin
          grant_vld_s = 1'b1;
          if (pending_r == 2'b11) begin
            grant_port_s = ~last_grant_r;
          end else begin
            grant_port_s = pending_r[1];
          end
          if (slot_len_r[grant_port_s] != 8'd0) begin
            state_nxt_s = ST_AR;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_AR: begin
        if (arvalid_r && arready_i) begin
          state_nxt_s = ST_R;
        end else begin
          state_nxt_s = ST_AR;
        end
      end
      ST_R: begin
        // A missing rlast still ends the burst once arlen+1 beats have arrived
        if (beat_s && (rlast_i || (beat_cnt_r == arlen_r))) begin
          burst_end_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_R;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request slots, AXI address registers, response pulses and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r    <= 2'b00;
      slot_addr_r  <= '0;
      slot_len_r   <= '0;
      last_grant_r <= 1'b1;
      active_r     <= 1'b0;
      beat_cnt_r   <= 8'd0;
      resp_ready_r <= 2'b00;
      data_valid_r <= 2'b00;
      data_r       <= '0;
      arvalid_r    <= 1'b0;
      araddr_r     <= '0;
      arlen_r      <= 8'd0;
      arsize_r     <= 3'd0;
      arburst_r    <= 2'b00;
      arid_r       <= '0;
      rready_r     <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      pending_r    <= (pending_r & ~grant_vec_s) | req_acc_s;
      resp_ready_r <= 2'b00;
      data_valid_r <= 2'b00;
      if (req_acc_s[0]) begin
        slot_addr_r[0] <= addr_i[0];
        slot_len_r[0]  <= data_len_i[0];
      end
      if (req_acc_s[1]) begin
        slot_addr_r[1] <= addr_i[1];
        slot_len_r[1]  <= data_len_i[1];
      end
      if ((req_drop_s != 2'b00) || r_err_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (grant_vld_s) begin
            last_grant_r <= grant_port_s;
            if (slot_len_r[grant_port_s] == 8'd0) begin
              resp_ready_r <= grant_vec_s;
            end else begin
              active_r  <= grant_port_s;
              arvalid_r <= 1'b1;
              araddr_r  <= slot_addr_r[grant_port_s];
              arlen_r   <= slot_len_r[grant_port_s] - 8'd1;
              arsize_r  <= ARSIZE;
              arburst_r <= 2'b01;
              arid_r    <= {{(ID_WIDTH-1){1'b0}}, grant_port_s};
            end
          end
        end
        ST_AR: begin
          if (arvalid_r && arready_i) begin
            arvalid_r    <= 1'b0;
            resp_ready_r <= active_vec_s;
            beat_cnt_r   <= 8'd0;
            rready_r     <= 1'b1;
          end
        end
        ST_R: begin
          if (beat_s) begin
            data_r       <= rdata_i;
            data_valid_r <= active_vec_s;
            beat_cnt_r   <= beat_cnt_r + 8'd1;
            if (burst_end_s) begin
              rready_r <= 1'b0;
            end
          end
        end
        default: begin
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_ready_o = resp_ready_r;
  assign data_valid_o = data_valid_r;
  assign data_o       = data_r;
  assign arvalid_o    = arvalid_r;
  assign araddr_o     = araddr_r;
  assign arlen_o      = arlen_r;
  assign arsize_o     = arsize_r;
  assign arburst_o    = arburst_r;
  assign arid_o       = arid_r;
  assign rready_o     = rready_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference of the arbiter and its AXI slave.
module tb_axi_rd_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       addr_valid_i;
  logic [1:0][31:0] addr_i;
  logic [1:0][7:0]  data_len_i;
  logic [1:0]       resp_ready_o, data_valid_o;
  logic [31:0]      data_o;
  logic             arvalid_o, arready_i;
  logic [31:0]      araddr_o;
  logic [7:0]       arlen_o;
  logic [2:0]       arsize_o;
  logic [1:0]       arburst_o;
  logic [3:0]       arid_o;
  logic             rvalid_i, rready_o;
  logic [31:0]      rdata_i;
  logic [1:0]       rresp_i;
  logic             rlast_i;
  logic [3:0]       rid_i;
  logic             err_o;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .addr_valid_i(addr_valid_i), .addr_i(addr_i), .data_len_i(data_len_i),
    .resp_ready_o(resp_ready_o), .data_valid_o(data_valid_o), .data_o(data_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
    .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o), .arid_o(arid_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .rid_i(rid_i), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: who has a request waiting, who is being served, what the AXI side must show
  logic [1:0]       m_pend;
  logic [1:0][31:0] m_addr;
  logic [1:0][7:0]  m_len;
  logic             m_last, m_busy, m_inar, m_port, m_err;
  int               m_cur_len, m_beats;
  logic [1:0]       e_resp, e_dv;
  logic [31:0]      e_data, e_araddr;
  logic             e_arv, e_rready, e_err;
  logic [7:0]       e_arlen;
  logic [2:0]       e_arsize;
  logic [1:0]       e_arburst;
  logic [3:0]       e_arid;
  int               grants[$];
  int               dv_cnt[2];

  // Stimulus knobs
  int               p_arready = 100, p_rvalid = 100, p_req = 0;
  int               inj_early = 0, inj_slverr = 0;
  bit               rdata_seq = 1'b0, d_rst = 1'b0;
  logic [1:0]       d_req = 2'b00;
  logic [1:0][31:0] d_addr;
  logic [1:0][7:0]  d_len;

  task automatic model_reset();
    m_pend = 2'b00; m_last = 1'b1; m_busy = 1'b0; m_inar = 1'b0; m_port = 1'b0;
    m_err = 1'b0; m_beats = 0; m_cur_len = 0;
    e_resp = 2'b00; e_dv = 2'b00; e_data = 32'd0; e_arv = 1'b0; e_araddr = 32'd0;
    e_arlen = 8'd0; e_arsize = 3'd0; e_arburst = 2'b00; e_arid = 4'd0;
    e_rready = 1'b0; e_err = 1'b0;
  endtask

  task automatic step();
    logic [1:0] acc;
    logic       g;
    rst          = d_rst;
    addr_valid_i = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if (d_req[p]) begin
        addr_valid_i[p] = 1'b1;
        addr_i[p]       = d_addr[p];
        data_len_i[p]   = d_len[p];
      end else if ((p_req > 0) && !m_pend[p] && !(m_busy && (m_port == 1'(p))) &&
                   ($urandom_range(0, 99) < p_req)) begin
        addr_valid_i[p] = 1'b1;
        addr_i[p]       = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        data_len_i[p]   = ($urandom_range(0, 39) == 0) ? 8'd255 : 8'($urandom_range(0, 9));
      end
    end
    d_req     = 2'b00;
    arready_i = ($urandom_range(0, 99) < p_arready);
    rvalid_i  = 1'b0;
    rlast_i   = 1'b0;
    rresp_i   = 2'b00;
    rid_i     = 4'd0;
    rdata_i   = $urandom();
    if (m_busy && !m_inar) begin
      rvalid_i = ($urandom_range(0, 99) < p_rvalid);
      rid_i    = {3'b000, m_port};
      if (rdata_seq) rdata_i = 32'h100 + 32'(m_beats);
      rlast_i  = (m_beats + 1 == m_cur_len) || (m_beats + 1 == inj_early);
      rresp_i  = (m_beats + 1 == inj_slverr) ? 2'b10 : 2'b00;
    end

    // Predict the outputs of the next cycle
    if (rst) begin
      model_reset();
    end else begin
      e_resp = 2'b00;
      e_dv   = 2'b00;
      acc    = 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (addr_valid_i[p]) begin
          if (m_pend[p] || (m_busy && (m_port == 1'(p)))) m_err = 1'b1;
          else acc[p] = 1'b1;
        end
      end
      if (!m_busy && (m_pend != 2'b00)) begin
        g = (m_pend == 2'b11) ? ~m_last : m_pend[1];
        m_last    = g;
        m_pend[g] = 1'b0;
        grants.push_back(int'(g));
        if (m_len[g] == 8'd0) begin
          e_resp[g] = 1'b1;
        end else begin
          m_busy = 1'b1; m_inar = 1'b1; m_port = g; m_cur_len = int'(m_len[g]);
          e_arv = 1'b1; e_araddr = m_addr[g]; e_arlen = m_len[g] - 8'd1;
          e_arid = {3'b000, g}; e_arsize = 3'd2; e_arburst = 2'b01;
        end
      end else if (m_busy && m_inar) begin
        if (arready_i) begin
          e_resp[m_port] = 1'b1; m_inar = 1'b0; m_beats = 0;
          e_arv = 1'b0; e_rready = 1'b1;
        end
      end else if (m_busy && rvalid_i) begin
        e_dv[m_port] = 1'b1;
        e_data       = rdata_i;
        if ((rid_i != {3'b000, m_port}) || (rresp_i != 2'b00) ||
            (rlast_i != (m_beats + 1 == m_cur_len))) m_err = 1'b1;
        m_beats++;
        if (rlast_i || (m_beats == m_cur_len)) begin
          m_busy = 1'b0; e_rready = 1'b0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          m_pend[p] = 1'b1; m_addr[p] = addr_i[p]; m_len[p] = data_len_i[p];
        end
      end
      e_err = m_err;
    end

    @(posedge clk);
    #1;
    chk("resp_ready", 64'(resp_ready_o), 64'(e_resp));
    chk("data_valid", 64'(data_valid_o), 64'(e_dv));
    chk("data",       64'(data_o),       64'(e_data));
    chk("arvalid",    64'(arvalid_o),    64'(e_arv));
    chk("araddr",     64'(araddr_o),     64'(e_araddr));
    chk("arlen",      64'(arlen_o),      64'(e_arlen));
    chk("arsize",     64'(arsize_o),     64'(e_arsize));
    chk("arburst",    64'(arburst_o),    64'(e_arburst));
    chk("arid",       64'(arid_o),       64'(e_arid));
    chk("rready",     64'(rready_o),     64'(e_rready));
    chk("err",        64'(err_o),        64'(e_err));
    dv_cnt[0] += int'(data_valid_o[0]);
    dv_cnt[1] += int'(data_valid_o[1]);
  endtask

  task automatic req(input int p, input logic [31:0] a, input logic [7:0] l);
    d_req[p]  = 1'b1;
    d_addr[p] = a;
    d_len[p]  = l;
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while ((m_busy || (m_pend != 2'b00) || (d_req != 2'b00)) && (i < budget)) begin
      step();
      i++;
    end
    chk("drain_done", 64'({m_busy, m_pend}), 64'd0);
  endtask

  initial begin
    addr_valid_i = 2'b00; addr_i = '0; data_len_i = '0; arready_i = 1'b0;
    rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00; rid_i = 4'd0; rdata_i = 32'd0;
    d_addr = '0; d_len = '0;
    model_reset();
    do_reset();
    do_reset();

    // icache alone, len 8, slave always ready
    grants.delete(); dv_cnt[0] = 0; dv_cnt[1] = 0; rdata_seq = 1'b1;
    req(0, 32'h1C00_0020, 8'd8);
    drain(60);
    rdata_seq = 1'b0;
    chk("t1_beats", 64'(dv_cnt[0]), 64'd8);
    chk("t1_grant", 64'(grants.size()), 64'd1);

    // Simultaneous misses out of reset: icache first, dcache after it
    do_reset();
    grants.delete();
    req(0, 32'h0000_1000, 8'd2);
    req(1, 32'h0000_2000, 8'd8);
    drain(100);
    chk("t2_first", 64'(grants[0]), 64'd0);
    chk("t2_second", 64'(grants[1]), 64'd1);

    // Four rounds of simultaneous requests must alternate grants
    grants.delete();
    for (int r = 0; r < 4; r++) begin
      req(0, 32'h0001_0000 + 32'(r * 64), 8'($urandom_range(1, 4)));
      req(1, 32'h0002_0000 + 32'(r * 64), 8'($urandom_range(1, 4)));
      drain(100);
    end
    for (int i = 0; i < 8; i++) chk("t3_alternate", 64'(grants[i]), 64'(i % 2));

    // Address stall: arvalid and araddr hold, no resp_ready until handshake
    p_arready = 0;
    req(1, 32'hABCD_0040, 8'd3);
    repeat (12) step();
    p_arready = 100;
    drain(50);

    // Null request on port 1
    dv_cnt[0] = 0; dv_cnt[1] = 0;
    req(1, 32'h0000_5000, 8'd0);
    drain(10);
    repeat (3) step();
    chk("t5_no_data", 64'(dv_cnt[1]), 64'd0);

    // Longest burst, arlen 254
    req(0, 32'h0003_0000, 8'd255);
    drain(400);

    // Re-request while pending is dropped and flagged
    req(0, 32'h0004_0000, 8'd4);
    step();
    req(0, 32'h0004_1000, 8'd4);
    drain(50);
    chk("t6_drop_err", 64'(err_o), 64'd1);
    do_reset();

    // Early rlast on beat 3 of 8, then next request still served
    inj_early = 3;
    req(0, 32'h0005_0000, 8'd8);
    drain(50);
    inj_early = 0;
    chk("t7_err", 64'(err_o), 64'd1);
    req(1, 32'h0005_1000, 8'd2);
    drain(50);
    do_reset();

    // SLVERR on beat 2, then next request still served
    inj_slverr = 2;
    req(1, 32'h0006_0000, 8'd4);
    drain(50);
    inj_slverr = 0;
    chk("t8_err", 64'(err_o), 64'd1);
    req(0, 32'h0006_1000, 8'd3);
    drain(50);
    do_reset();

    // Reset in the middle of a burst
    req(0, 32'h0007_0000, 8'd8);
    repeat (5) step();
    chk("t9_in_burst", 64'(m_busy), 64'd1);
    do_reset();
    chk("t9_err_clear", 64'(err_o), 64'd0);

    // Randomized traffic with random slave stalls
    p_req = 15; p_arready = 60; p_rvalid = 70;
    repeat (3000) step();
    p_req = 0;
    drain(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
